// File: rtl/hazard_control_unit.sv
// hazard_control_unit: RAW hazard detection, branch flush sequencing,
// memory-wait freeze and saturating stall/flush counters beside decode.
// Optional feature: define HAZARD_FORWARD_EN to enable operand forwarding.
// With forwarding, only load-use hazards stall. Without it, any pending
// producer stalls.
module hazard_control_unit #(
  parameter int unsigned REG_ADDR_W   = 4,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16,
  parameter bit          ZERO_REG     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         idex_rd,
  input  logic [REG_ADDR_W-1:0]         exmem_rd,
  input  logic [REG_ADDR_W-1:0]         memwb_rd,
  input  logic                          idex_wr,
  input  logic                          exmem_wr,
  input  logic                          memwb_wr,
  input  logic                          idex_is_load,
  input  logic                          branch_taken,
  input  logic                          mem_busy,
  output logic                          pc_write,
  output logic                          if_id_write,
  output logic                          id_ex_bubble,
  output logic                          if_id_flush,
  output logic [NUM_SRC*2-1:0]          fwd_sel,
  output logic [CNT_W-1:0]              stall_count,
  output logic [CNT_W-1:0]              flush_count
);

  localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    flush_q, flush_d;

  logic [NUM_SRC-1:0]   m_idex, m_exmem, m_memwb;
  logic [NUM_SRC*2-1:0] fwd_raw;
  logic                 hazard_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Per-source match against each downstream destination, plus forwarding choice
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [REG_ADDR_W-1:0] rs;
    logic                  live;
    assign rs         = id_rs_addr[s*REG_ADDR_W +: REG_ADDR_W];
    assign live       = id_rs_used[s] & !(ZERO_REG && (rs == '0));
    assign m_idex[s]  = live & idex_wr  & (idex_rd  == rs);
    assign m_exmem[s] = live & exmem_wr & (exmem_rd == rs);
    assign m_memwb[s] = live & memwb_wr & (memwb_rd == rs);
`ifdef HAZARD_FORWARD_EN
    assign fwd_raw[2*s +: 2] = m_idex[s]  ? 2'b01 :
                               m_exmem[s] ? 2'b10 :
                               m_memwb[s] ? 2'b11 : 2'b00;
`else
    assign fwd_raw[2*s +: 2] = 2'b00;
`endif
  end

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded in time
  assign hazard_c = idex_is_load & (|m_idex);
`else
  // Any in-flight producer of a source must retire first
  assign hazard_c = |(m_idex | m_exmem | m_memwb);
  logic unused_load;
  assign unused_load = idex_is_load;
`endif

  // Next-state and control outputs; priority mem_busy > branch > flush > hazard
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    stall_d      = stall_q;
    flush_d      = flush_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (!rst_n) begin
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      // whole pipeline frozen, nothing advances
    end else if (branch_taken) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_d      = sat_inc(flush_q);
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        fcnt_d  = FCNT_RELOAD;
      end else begin
        state_d = ST_RUN;
        fcnt_d  = '0;
      end
    end else if (state_q == ST_FLUSH) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_d      = sat_inc(flush_q);
      fcnt_d       = fcnt_q - FCNT_W'(1);
      if (fcnt_q == FCNT_W'(1)) begin
        state_d = ST_RUN;
      end
    end else if (hazard_c) begin
      id_ex_bubble = 1'b1;
      stall_d      = sat_inc(stall_q);
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  // Forwarding is meaningless when ID is bubbled or flushed
  assign fwd_sel     = (id_ex_bubble | if_id_flush) ? '0 : fwd_raw;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

  // State, flush down-counter and performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios followed
// by randomized traffic, all compared against a cycle-level behavioural model.
module tb_hazard_control_unit;

  localparam int unsigned RW   = 4;
  localparam int unsigned NS   = 2;
  localparam int unsigned FC   = 3;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS*RW-1:0]  id_rs_addr;
  logic [NS-1:0]     id_rs_used;
  logic [RW-1:0]     idex_rd, exmem_rd, memwb_rd;
  logic              idex_wr, exmem_wr, memwb_wr;
  logic              idex_is_load, branch_taken, mem_busy;
  logic              pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic [NS*2-1:0]   fwd_sel;
  logic [CW-1:0]     stall_count, flush_count;

  int n_total = 0;
  int n_bad   = 0;

  // model state: flush cycles still owed after the current one, counters
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_control_unit #(
    .REG_ADDR_W(RW), .NUM_SRC(NS), .FLUSH_CYCLES(FC), .CNT_W(CW), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .idex_rd(idex_rd), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .idex_wr(idex_wr), .exmem_wr(exmem_wr), .memwb_wr(memwb_wr),
    .idex_is_load(idex_is_load), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .fwd_sel(fwd_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit src_match(input int s, input logic [RW-1:0] rd, input logic wr);
    logic [RW-1:0] rs;
    rs = id_rs_addr[s*RW +: RW];
    return id_rs_used[s] && wr && (rd == rs) && (rs != 0);
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic clear_inputs();
    id_rs_addr = '0; id_rs_used = '0;
    idex_rd = '0; exmem_rd = '0; memwb_rd = '0;
    idex_wr = 1'b0; exmem_wr = 1'b0; memwb_wr = 1'b0;
    idex_is_load = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  // Called at a falling edge with inputs already applied; checks, then advances one clock
  task automatic step();
    bit            hz;
    bit            a, b, c;
    logic [NS*2-1:0] fw;
    bit            e_pc, e_wr, e_bub, e_fl;
    #1;
    if (!rst_n) begin
      m_left = 0; m_stall = 0; m_flush = 0;
    end
    hz = 1'b0;
    fw = '0;
    for (int s = 0; s < NS; s++) begin
      a = src_match(s, idex_rd, idex_wr);
      b = src_match(s, exmem_rd, exmem_wr);
      c = src_match(s, memwb_rd, memwb_wr);
`ifdef HAZARD_FORWARD_EN
      if (a && idex_is_load) hz = 1'b1;
      fw[2*s +: 2] = a ? 2'd1 : b ? 2'd2 : c ? 2'd3 : 2'd0;
`else
      if (a || b || c) hz = 1'b1;
`endif
    end
    if (!rst_n)                          {e_pc, e_wr, e_bub, e_fl} = 4'b0010;
    else if (mem_busy)                   {e_pc, e_wr, e_bub, e_fl} = 4'b0000;
    else if (branch_taken || m_left > 0) {e_pc, e_wr, e_bub, e_fl} = 4'b1111;
    else if (hz)                         {e_pc, e_wr, e_bub, e_fl} = 4'b0010;
    else                                 {e_pc, e_wr, e_bub, e_fl} = 4'b1100;
    if (e_bub || e_fl) fw = '0;
    check_val("pc_write",     32'(pc_write),     32'(e_pc));
    check_val("if_id_write",  32'(if_id_write),  32'(e_wr));
    check_val("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
    check_val("if_id_flush",  32'(if_id_flush),  32'(e_fl));
    check_val("fwd_sel",      32'(fwd_sel),      32'(fw));
    check_val("stall_count",  32'(stall_count),  32'(m_stall));
    check_val("flush_count",  32'(flush_count),  32'(m_flush));
    @(posedge clk);
    if (rst_n && !mem_busy) begin
      if (branch_taken) begin
        m_flush = sat(m_flush);
        m_left  = FC - 1;
      end else if (m_left > 0) begin
        m_flush = sat(m_flush);
        m_left--;
      end else if (hz) begin
        m_stall = sat(m_stall);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    do_reset();
    idle(2);
    check_val("idle_stall0", 32'(stall_count), 32'd0);
    check_val("idle_flush0", 32'(flush_count), 32'd0);

    // single branch: FC flush cycles
    branch_taken = 1'b1; step();
    idle(4);
    check_val("flush_one_branch", 32'(flush_count), 32'd3);
    // second branch on flush cycle 2 extends to 4 cycles
    branch_taken = 1'b1; step();
    branch_taken = 1'b1; step();
    idle(5);
    check_val("flush_rebranch", 32'(flush_count), 32'd7);
    // reset in the middle of a flush
    branch_taken = 1'b1; step();
    clear_inputs(); step();
    do_reset();
    idle(2);
    check_val("flush_abort", 32'(flush_count), 32'd0);

    // mem_busy freeze during flush with concurrent hazard
    branch_taken = 1'b1; step();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      mem_busy = 1'b1;
      id_rs_addr[0 +: RW] = 4'd6; id_rs_used = 2'b01;
      idex_rd = 4'd6; idex_wr = 1'b1; idex_is_load = 1'b1;
      step();
    end
    idle(4);
    check_val("busy_flush", 32'(flush_count), 32'd3);
    check_val("busy_stall", 32'(stall_count), 32'd0);

    // load-use on rs0 then producer in EX/MEM
    do_reset();
    id_rs_addr[0 +: RW] = 4'd3; id_rs_used = 2'b01;
    idex_rd = 4'd3; idex_wr = 1'b1; idex_is_load = 1'b1;
    step();
    idex_wr = 1'b0; idex_is_load = 1'b0;
    exmem_rd = 4'd3; exmem_wr = 1'b1;
    step();
    idle(1);
`ifdef HAZARD_FORWARD_EN
    check_val("load_use_stall", 32'(stall_count), 32'd1);
`else
    check_val("load_use_stall", 32'(stall_count), 32'd2);
`endif
    // rs1 producer walking EX/MEM -> MEM/WB -> gone
    id_rs_addr[RW +: RW] = 4'd5; id_rs_used = 2'b10;
    exmem_rd = 4'd5; exmem_wr = 1'b1;
    step();
    exmem_wr = 1'b0;
    memwb_rd = 4'd5; memwb_wr = 1'b1;
    step();
    idle(1);
`ifdef HAZARD_FORWARD_EN
    check_val("raw_walk_stall", 32'(stall_count), 32'd1);
`else
    check_val("raw_walk_stall", 32'(stall_count), 32'd4);
`endif

    // register zero never hazards
    do_reset();
    id_rs_used = 2'b11;
    idex_rd = 4'd0; idex_wr = 1'b1; idex_is_load = 1'b1;
    exmem_wr = 1'b1; memwb_wr = 1'b1;
    step(); step();
    idle(1);
    check_val("zero_reg", 32'(stall_count), 32'd0);

    // persistent hazard saturates the stall counter
    id_rs_addr[0 +: RW] = 4'd2; id_rs_used = 2'b01;
    idex_rd = 4'd2; idex_wr = 1'b1; idex_is_load = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_val("stall_sat", 32'(stall_count), 32'(CMAX));

    // randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      id_rs_addr   = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      id_rs_used   = 2'($urandom);
      idex_rd      = 4'($urandom_range(0, 3));
      exmem_rd     = 4'($urandom_range(0, 3));
      memwb_rd     = 4'($urandom_range(0, 3));
      idex_wr      = 1'($urandom);
      exmem_wr     = 1'($urandom);
      memwb_wr     = 1'($urandom);
      idex_is_load = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      mem_busy     = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
